// File: rtl/multi_seq_detector_if.sv
// Bus bundle for the multi-channel sequence detector: serial inputs, config port and status outputs.
interface multi_seq_detector_if #(
   parameter int unsigned N_CH    = 3,
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 16
);
   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   logic [N_CH-1:0]       din;
   logic [N_CH-1:0]       din_valid;
   logic                  cfg_we;
   logic [CH_W-1:0]       cfg_ch;
   logic [LEN_W-1:0]      cfg_len;
   logic [MAX_LEN-1:0]    cfg_pattern;
   logic                  cfg_overlap;
   logic                  cnt_clr;
   logic [N_CH-1:0]       hit;
   logic                  z;
   logic [N_CH*CNT_W-1:0] hit_count;

   modport master (
      output din, din_valid, cfg_we, cfg_ch, cfg_len, cfg_pattern, cfg_overlap, cnt_clr,
      input  hit, z, hit_count
   );

   modport slave (
      input  din, din_valid, cfg_we, cfg_ch, cfg_len, cfg_pattern, cfg_overlap, cnt_clr,
      output hit, z, hit_count
   );
endinterface

// File: rtl/multi_seq_detector.sv
// N-channel runtime-programmable serial pattern detector with overlap control
// and saturating per-channel hit counters.
module multi_seq_detector #(
   parameter int unsigned N_CH    = 3,
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   multi_seq_detector_if.slave   bus
);
   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   logic [N_CH-1:0][MAX_LEN-1:0] pat_q,  pat_d;
   logic [N_CH-1:0][LEN_W-1:0]   len_q,  len_d;
   logic [N_CH-1:0]              ovl_q,  ovl_d;
   logic [N_CH-1:0][MAX_LEN-1:0] hist_q, hist_d;
   logic [N_CH-1:0][LEN_W-1:0]   fill_q, fill_d;
   logic [N_CH-1:0]              hit_q,  hit_d;
   logic [N_CH-1:0][CNT_W-1:0]   cnt_q,  cnt_d;

   logic [LEN_W-1:0] cfg_len_sat;

   // Lengths beyond the history depth are clamped rather than rejected
   assign cfg_len_sat = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;

   // Next-state for every channel: config load, sampling, matching and counting
   always_comb begin
      logic [MAX_LEN-1:0] hist_n;
      logic [MAX_LEN-1:0] mask;
      logic [LEN_W-1:0]   fill_n;
      logic               match;

      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;
      hit_d  = '0;
      cnt_d  = cnt_q;
      hist_n = '0;
      mask   = '0;
      fill_n = '0;
      match  = 1'b0;

      for (int c = 0; c < int'(N_CH); c++) begin
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (LEN_W'(i) < len_q[c]);
         end
         hist_n = MAX_LEN'({hist_q[c], bus.din[c]});
         fill_n = (fill_q[c] == len_q[c]) ? len_q[c] : LEN_W'(fill_q[c] + 1'b1);
         match  = (fill_n == len_q[c]) && ((hist_n & mask) == (pat_q[c] & mask));

         if (bus.cfg_we && (bus.cfg_ch == CH_W'(c))) begin
            pat_d[c]  = bus.cfg_pattern;
            len_d[c]  = cfg_len_sat;
            ovl_d[c]  = bus.cfg_overlap;
            hist_d[c] = '0;
            fill_d[c] = '0;
         end else if (bus.din_valid[c] && (len_q[c] != '0)) begin
            hist_d[c] = hist_n;
            hit_d[c]  = match;
            // Non-overlap discards the matched bits so a full fresh pattern is needed
            fill_d[c] = (match && !ovl_q[c]) ? '0 : fill_n;
         end

         if (bus.cnt_clr) begin
            cnt_d[c] = CNT_W'(hit_d[c]);
         end else if (hit_d[c] && !(&cnt_q[c])) begin
            cnt_d[c] = CNT_W'(cnt_q[c] + 1'b1);
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pat_q  <= '0;
         len_q  <= '0;
         ovl_q  <= '1;
         hist_q <= '0;
         fill_q <= '0;
         hit_q  <= '0;
         cnt_q  <= '0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         hit_q  <= hit_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.hit       = hit_q;
   assign bus.z         = |hit_q;
   assign bus.hit_count = cnt_q;

endmodule
